// File: rtl/occupancy_pkg.sv
// Shared occupancy-tracker definitions: default parameters, popcount and the clamp decision.
package occupancy_pkg;

    localparam int unsigned N_DOORS_DEF     = 4;
    localparam int unsigned CNT_W_DEF       = 8;
    localparam int unsigned DEB_CYCLES_DEF  = 4;
    localparam int unsigned NEAR_MARGIN_DEF = 2;
    localparam int unsigned MAX_DOORS       = 32;
    localparam int unsigned POP_W           = 6;

    typedef enum logic [1:0] {
        SEL_SUM  = 2'd0,
        SEL_ZERO = 2'd1,
        SEL_HOLD = 2'd2
    } occ_sel_e;

    typedef struct packed {
        occ_sel_e sel;
        logic     overflow;
        logic     underflow;
    } sat_res_t;

    function automatic logic [POP_W-1:0] popcount(input logic [MAX_DOORS-1:0] v);
        logic [POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(MAX_DOORS); i++) begin
            c = c + POP_W'(v[i]);
        end
        return c;
    endfunction

    // Width-independent clamp decision; SEL_HOLD means keep max(occupancy, limit).
    function automatic sat_res_t sat_update(input logic sum_neg,
                                            input logic sum_gt_max,
                                            input logic in_gt_out);
        sat_res_t r;
        r.sel       = SEL_SUM;
        r.overflow  = 1'b0;
        r.underflow = 1'b0;
        if (sum_neg) begin
            r.sel       = SEL_ZERO;
            r.underflow = 1'b1;
        end else if (sum_gt_max && in_gt_out) begin
            r.sel      = SEL_HOLD;
            r.overflow = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/multi_door_occupancy_tracker_if.sv
// Sensor inputs and status outputs of the occupancy tracker.
interface multi_door_occupancy_tracker_if #(
    parameter int unsigned N_DOORS = 4,
    parameter int unsigned CNT_W   = 8
);
    logic [N_DOORS-1:0] entry_sensor;
    logic [N_DOORS-1:0] exit_sensor;
    logic [CNT_W-1:0]   max_occupancy;
    logic               clear_err;
    logic [CNT_W-1:0]   occupancy;
    logic               max_capacity;
    logic               near_capacity;
    logic               entry_denied;
    logic               overflow_err;
    logic               underflow_err;

    modport master (
        output entry_sensor, exit_sensor, max_occupancy, clear_err,
        input  occupancy, max_capacity, near_capacity, entry_denied,
               overflow_err, underflow_err
    );

    modport slave (
        input  entry_sensor, exit_sensor, max_occupancy, clear_err,
        output occupancy, max_capacity, near_capacity, entry_denied,
               overflow_err, underflow_err
    );
endinterface

// File: rtl/sensor_debounce.sv
// One sensor bit: 2-flop synchroniser, stable-count debouncer, registered rising-edge pulse.
module sensor_debounce #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_rise
);
    localparam int unsigned DCNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DCNT_W-1:0] CNT_LAST = DCNT_W'(DEB_CYCLES - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_filt;
    logic              r_filt_q;
    logic              r_rise;
    logic [DCNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_filt   <= 1'b0;
            r_filt_q <= 1'b0;
            r_rise   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1  <= i_raw;
            r_sync2  <= r_sync1;
            r_filt_q <= r_filt;
            r_rise   <= r_filt & ~r_filt_q;
            // Filtered level flips on the DEB_CYCLES-th consecutive disagreeing cycle.
            if (r_sync2 == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_filt <= r_sync2;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + DCNT_W'(1);
            end
        end
    end

    assign o_rise = r_rise;
endmodule

// File: rtl/multi_door_occupancy_tracker.sv
// Sums debounced entry/exit events from all doors into a clamped occupancy count with status flags.
module multi_door_occupancy_tracker
    import occupancy_pkg::*;
#(
    parameter int unsigned N_DOORS     = N_DOORS_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int unsigned NEAR_MARGIN = NEAR_MARGIN_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    multi_door_occupancy_tracker_if.slave  bus
);
    localparam int unsigned SUM_W = CNT_W + 2;

    logic [N_DOORS-1:0] w_entry_ev;
    logic [N_DOORS-1:0] w_exit_ev;
    logic [POP_W-1:0]   w_n_in;
    logic [POP_W-1:0]   w_n_out;
    logic [SUM_W-1:0]   w_sum;
    logic               w_sum_neg;
    logic               w_sum_gt;
    sat_res_t           w_res;
    logic [CNT_W-1:0]   w_next_occ;
    logic [CNT_W-1:0]   w_near_lim;

    logic [CNT_W-1:0]   r_occ;
    logic               r_max_cap;
    logic               r_near_cap;
    logic               r_denied;
    logic               r_ovf;
    logic               r_unf;

    for (genvar d = 0; d < int'(N_DOORS); d++) begin : g_door
        sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_entry (
            .clk    (clk),
            .rst    (rst),
            .i_raw  (bus.entry_sensor[d]),
            .o_rise (w_entry_ev[d])
        );
        sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_exit (
            .clk    (clk),
            .rst    (rst),
            .i_raw  (bus.exit_sensor[d]),
            .o_rise (w_exit_ev[d])
        );
    end

    // Net all doors' events, then pick the clamped next occupancy.
    always_comb begin
        w_n_in     = popcount(MAX_DOORS'(w_entry_ev));
        w_n_out    = popcount(MAX_DOORS'(w_exit_ev));
        w_sum      = SUM_W'(r_occ) + SUM_W'(w_n_in) - SUM_W'(w_n_out);
        w_sum_neg  = w_sum[SUM_W-1];
        w_sum_gt   = !w_sum_neg && (w_sum > SUM_W'(bus.max_occupancy));
        w_res      = sat_update(w_sum_neg, w_sum_gt, w_n_in > w_n_out);
        w_next_occ = CNT_W'(w_sum);
        case (w_res.sel)
            SEL_ZERO: w_next_occ = '0;
            SEL_HOLD: w_next_occ = (r_occ > bus.max_occupancy) ? r_occ : bus.max_occupancy;
            default:  w_next_occ = CNT_W'(w_sum);
        endcase
        w_near_lim = (bus.max_occupancy >= CNT_W'(NEAR_MARGIN))
                   ? bus.max_occupancy - CNT_W'(NEAR_MARGIN) : '0;
    end

    // A new error in the same cycle as clear_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ      <= '0;
            r_max_cap  <= 1'b0;
            r_near_cap <= 1'b0;
            r_denied   <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            r_occ      <= w_next_occ;
            r_max_cap  <= (w_next_occ >= bus.max_occupancy);
            r_near_cap <= (w_next_occ >= w_near_lim);
            r_denied   <= w_res.overflow;
            r_ovf      <= w_res.overflow  | (r_ovf & ~bus.clear_err);
            r_unf      <= w_res.underflow | (r_unf & ~bus.clear_err);
        end
    end

    assign bus.occupancy     = r_occ;
    assign bus.max_capacity  = r_max_cap;
    assign bus.near_capacity = r_near_cap;
    assign bus.entry_denied  = r_denied;
    assign bus.overflow_err  = r_ovf;
    assign bus.underflow_err = r_unf;
endmodule

// File: tb/tb_multi_door_occupancy_tracker.sv
// Directed scoreboard bench for multi_door_occupancy_tracker (4 doors, debounce 4, margin 2).
module tb_multi_door_occupancy_tracker;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multi_door_occupancy_tracker_if #(.N_DOORS(4), .CNT_W(8)) bus ();

    multi_door_occupancy_tracker #(
        .N_DOORS(4), .CNT_W(8), .DEB_CYCLES(4), .NEAR_MARGIN(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        int         tag;
        logic [7:0] occ;
        logic       mc;
        logic       nc;
        logic       den;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   tag_n = 0;

    logic [7:0] p_occ;
    logic       p_mc, p_nc, p_ovf, p_unf;

    task automatic push(input int due, input logic [7:0] occ, input logic mc, input logic nc,
                        input logic den, input logic ovf, input logic unf);
        exp_t e;
        e.due = due; e.tag = tag_n; e.occ = occ; e.mc = mc; e.nc = nc;
        e.den = den; e.ovf = ovf; e.unf = unf;
        tag_n++;
        q.push_back(e);
    endtask

    // Monitor: compare every expectation that falls due at this sampling point.
    exp_t m;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due < cyc) begin
            m = q.pop_front();
            total++;
            bad++;
            $display("FAIL chk%0d missed: due cycle %0d, now %0d", m.tag, m.due, cyc);
        end
        while (q.size() > 0 && q[0].due == cyc) begin
            m = q.pop_front();
            total++;
            if (bus.occupancy !== m.occ || bus.max_capacity !== m.mc ||
                bus.near_capacity !== m.nc || bus.entry_denied !== m.den ||
                bus.overflow_err !== m.ovf || bus.underflow_err !== m.unf) begin
                bad++;
                $display("FAIL chk%0d cyc %0d: got occ=%0d mc=%b nc=%b den=%b ovf=%b unf=%b, want occ=%0d mc=%b nc=%b den=%b ovf=%b unf=%b",
                         m.tag, cyc, bus.occupancy, bus.max_capacity, bus.near_capacity,
                         bus.entry_denied, bus.overflow_err, bus.underflow_err,
                         m.occ, m.mc, m.nc, m.den, m.ovf, m.unf);
            end
        end
    end

    // Raise sensors for one event; expect old state 7 samples later and the new state at 8.
    task automatic ev(input logic [3:0] e, input logic [3:0] x, input logic [7:0] occ,
                      input logic mc, input logic nc, input logic den,
                      input logic ovf, input logic unf);
        int c;
        c = cyc;
        bus.entry_sensor = e;
        bus.exit_sensor  = x;
        push(c + 7, p_occ, p_mc, p_nc, 1'b0, p_ovf, p_unf);
        push(c + 8, occ, mc, nc, den, ovf, unf);
        push(c + 9, occ, mc, nc, 1'b0, ovf, unf);
        p_occ = occ; p_mc = mc; p_nc = nc; p_ovf = ovf; p_unf = unf;
        repeat (6) @(negedge clk);
        bus.entry_sensor = '0;
        bus.exit_sensor  = '0;
        repeat (14) @(negedge clk);
    endtask

    task automatic clr();
        bus.clear_err = 1'b1;
        p_ovf = 1'b0;
        p_unf = 1'b0;
        push(cyc + 1, p_occ, p_mc, p_nc, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.clear_err = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int c;
        int r;
        rst = 1'b1;
        bus.entry_sensor  = '0;
        bus.exit_sensor   = '0;
        bus.max_occupancy = 8'd10;
        bus.clear_err     = 1'b0;
        p_occ = 8'd0; p_mc = 1'b0; p_nc = 1'b0; p_ovf = 1'b0; p_unf = 1'b0;

        repeat (2) @(negedge clk);
        push(cyc + 1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        push(cyc + 1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // Single entry, then build to 3 and fill up (max 10, near from 8)
        ev(4'b0001, 4'b0000, 8'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ev(4'b0011, 4'b0000, 8'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ev(4'b1111, 4'b0000, 8'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ev(4'b0001, 4'b0000, 8'd8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ev(4'b0001, 4'b0000, 8'd9,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ev(4'b0111, 4'b0000, 8'd10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        clr();

        // Drain, underflow, then same-door entry+exit nets out
        ev(4'b0000, 4'b1111, 8'd6,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ev(4'b0000, 4'b1111, 8'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ev(4'b0000, 4'b0001, 8'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ev(4'b0000, 4'b0110, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        ev(4'b1111, 4'b0000, 8'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        ev(4'b0001, 4'b0000, 8'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        ev(4'b1000, 4'b1000, 8'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        clr();

        // 3-cycle glitch must not count
        c = cyc;
        bus.entry_sensor = 4'b0100;
        repeat (3) @(negedge clk);
        bus.entry_sensor = '0;
        push(c + 10, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (15) @(negedge clk);

        // Lowered limit below current count
        ev(4'b0111, 4'b0000, 8'd8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.max_occupancy = 8'd6;
        p_mc = 1'b1; p_nc = 1'b1;
        push(cyc + 1, 8'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        ev(4'b0001, 4'b0000, 8'd8,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        ev(4'b0000, 4'b0001, 8'd7,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset mid-debounce, entry held high through reset
        bus.entry_sensor = 4'b0001;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        push(cyc + 1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        r = cyc;
        push(r + 1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(r + 7, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(r + 8, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (12) @(negedge clk);
        bus.entry_sensor = '0;

        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations outstanding, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
